// File: rtl/vga_line_prefetch.sv
// Read-ahead FIFO between the SRAM controller read port and the VGA pixel path.
// Walks the frame buffer sequentially, one read in flight, showing the FIFO head to the VGA side.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   frame_start        one-cycle restart pulse (flush FIFO, address 0)
//   sram_ready/data    controller idle/done flag and read data
//   sram_addr          registered read address
//   sram_start_n       active-low one-cycle request strobe
//   sram_rw            constant read
//   pix_rd             pop request from the VGA side
//   pix_data/valid     show-ahead FIFO head and non-empty flag
//   fill               FIFO occupancy
//   underflow          sticky pop-while-empty flag
//   frame_done         all reads of the frame completed
module vga_line_prefetch #(
   parameter int FRAME_WORDS = 19200,
   parameter int DEPTH       = 16,
   parameter int DATA_W      = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_start,
   input  logic                     sram_ready,
   input  logic [15:0]              sram_data,
   output logic [15:0]              sram_addr,
   output logic                     sram_start_n,
   output logic                     sram_rw,
   input  logic                     pix_rd,
   output logic [DATA_W-1:0]        pix_data,
   output logic                     pix_valid,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     underflow,
   output logic                     frame_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_DONE,
      S_DRAIN
   } state_t;

   state_t state_q;
   state_t state_d;

   // Remembers that the abandoned handshake has already seen ready low,
   // so DRAIN only needs the rising edge back to idle.
   logic drain_low_q;
   logic drain_low_d;

   logic push;
   logic pop;
   logic last;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;

   assign sram_rw   = 1'b1;
   assign last      = (sram_addr == 16'(FRAME_WORDS - 1));
   assign pix_valid = (fill != '0);
   assign pix_data  = mem[rd_ptr];

   // A pop on an empty FIFO never moves the read pointer, even when a word
   // is being written in the same cycle; that word stays for the next pop.
   assign pop = pix_rd && (fill != '0);

   generate
      if (DATA_W < 16) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^sram_data[15:DATA_W];
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      drain_low_d = drain_low_q;
      push        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (fill < FW'(DEPTH) && !frame_done && sram_ready)
               state_d = S_REQ;
         end
         S_REQ: begin
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (!sram_ready)
               state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (sram_ready) begin
               push    = 1'b1;
               state_d = last ? S_DONE : S_IDLE;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         S_DRAIN: begin
            drain_low_d = drain_low_q | !sram_ready;
            if (drain_low_q && sram_ready)
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Restart wins over everything: the in-flight word is discarded and
      // an unfinished handshake is run to completion in DRAIN.
      if (frame_start) begin
         push = 1'b0;
         unique case (state_q)
            S_REQ, S_WAIT_ACK: begin
               state_d     = S_DRAIN;
               drain_low_d = !sram_ready;
            end
            S_WAIT_DONE: begin
               if (sram_ready) begin
                  state_d = S_IDLE;
               end else begin
                  state_d     = S_DRAIN;
                  drain_low_d = 1'b1;
               end
            end
            S_DRAIN: begin
               state_d = S_DRAIN;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         drain_low_q  <= 1'b0;
         sram_start_n <= 1'b1;
         sram_addr    <= '0;
         frame_done   <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_low_q  <= drain_low_d;
         sram_start_n <= (state_d != S_REQ);
         if (frame_start) begin
            sram_addr  <= '0;
            frame_done <= 1'b0;
         end else if (push) begin
            if (last) begin
               sram_addr  <= '0;
               frame_done <= 1'b1;
            end else begin
               sram_addr <= sram_addr + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= sram_data[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || frame_start) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         underflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (pix_rd && fill == '0)
            underflow <= 1'b1;
         if (push && !pop)
            fill <= fill + FW'(1);
         else if (!push && pop)
            fill <= fill - FW'(1);
      end
   end

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Testbench for vga_line_prefetch: SRAM controller model, FIFO/frame scoreboard
// checked every cycle, and directed scenarios with literal expectations.
module tb_vga_line_prefetch;

   localparam int FW    = 20;
   localparam int DEPTH = 16;
   localparam int DW    = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          frame_start = 1'b0;
   logic          sram_ready = 1'b1;
   logic [15:0]   sram_data = 16'h0;
   logic [15:0]   sram_addr;
   logic          sram_start_n;
   logic          sram_rw;
   logic          pix_rd = 1'b0;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic [4:0]    fill;
   logic          underflow;
   logic          frame_done;

   int checks = 0;
   int failures = 0;

   vga_line_prefetch #(
      .FRAME_WORDS(FW),
      .DEPTH(DEPTH),
      .DATA_W(DW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .frame_start(frame_start),
      .sram_ready(sram_ready),
      .sram_data(sram_data),
      .sram_addr(sram_addr),
      .sram_start_n(sram_start_n),
      .sram_rw(sram_rw),
      .pix_rd(pix_rd),
      .pix_data(pix_data),
      .pix_valid(pix_valid),
      .fill(fill),
      .underflow(underflow),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] pat(input int a);
      return 12'((a * 13 + 7) & 'hFFF);
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM controller model: drops ready for busy cycles after a strobe,
   // then raises it with the addressed word.
   int busy = 2;
   int cnt = 0;
   int lat_addr = 0;
   logic rst_q;

   always begin
      @(posedge clk);
      rst_q = reset;
      #2;
      if (rst_q) begin
         sram_ready = 1'b1;
         cnt = 0;
      end else if (!sram_start_n) begin
         sram_ready = 1'b0;
         sram_data = 16'hDEAD;
         cnt = busy;
         lat_addr = int'(sram_addr);
      end else if (!sram_ready) begin
         cnt--;
         if (cnt == 0) begin
            sram_ready = 1'b1;
            sram_data = {4'hA, pat(lat_addr)};
         end
      end
   end

   // Scoreboard: a queue of expected pixels plus frame bookkeeping.
   logic [11:0] q[$];
   bit m_uf = 0;
   bit m_done = 0;
   bit m_out = 0;
   bit m_low = 0;
   bit m_live = 0;
   bit comp = 0;
   bit prev_sn = 1;
   int m_addr = 0;
   int req_count = 0;

   always @(negedge clk) begin
      check("fill", 32'(fill), q.size());
      check("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
      if (q.size() != 0)
         check("pix_data", 32'(pix_data), 32'(q[0]));
      check("underflow", 32'(underflow), 32'(m_uf));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("sram_addr", 32'(sram_addr), m_addr);
      check("sram_rw", 32'(sram_rw), 1);
      if (!sram_start_n) begin
         req_count++;
         check("req_allowed",
               32'(q.size() < DEPTH && !m_out && !m_done && prev_sn), 1);
         m_out = 1;
         m_low = 0;
         m_live = 1;
      end
      prev_sn = sram_start_n;

      if (reset) begin
         q.delete();
         m_uf = 0;
         m_done = 0;
         m_addr = 0;
         m_out = 0;
         m_low = 0;
         m_live = 0;
      end else begin
         comp = m_out && m_low && sram_ready;
         if (m_out && !sram_ready)
            m_low = 1;
         if (frame_start) begin
            q.delete();
            m_uf = 0;
            m_done = 0;
            m_addr = 0;
            m_live = 0;
         end else begin
            if (pix_rd) begin
               if (q.size() != 0)
                  void'(q.pop_front());
               else
                  m_uf = 1;
            end
            if (comp && m_live) begin
               q.push_back(pat(m_addr));
               if (m_addr == FW - 1) begin
                  m_addr = 0;
                  m_done = 1;
               end else begin
                  m_addr++;
               end
            end
         end
         if (comp) begin
            m_out = 0;
            m_low = 0;
            m_live = 0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int addr, input string name);
      bit found;
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (!sram_start_n && (addr < 0 || int'(sram_addr) == addr))
            found = 1;
      end
      check(name, 32'(found), 1);
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   int pops;

   initial begin
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      req_count = 0;
      @(negedge clk);
      check("rst_start_n", 32'(sram_start_n), 1);
      check("rst_addr", 32'(sram_addr), 0);
      check("rst_fill", 32'(fill), 0);
      check("rst_valid", 32'(pix_valid), 0);
      check("rst_pix_data", 32'(pix_data), 0);
      check("rst_underflow", 32'(underflow), 0);
      check("rst_frame_done", 32'(frame_done), 0);

      // Fill with no pops
      for (int i = 0; i < 300 && fill != 5'd16; i++)
         @(negedge clk);
      check("fill_full", 32'(fill), 16);
      check("fill_head", 32'(pix_data), 32'h007);
      repeat (30) @(negedge clk);
      check("fill_reqs", req_count, 16);
      check("fill_hold", 32'(fill), 16);

      // Steady stream: pop every 5th cycle
      pops = 0;
      for (int c = 0; c < 400 && pops < FW; c++) begin
         @(posedge clk);
         #1;
         pix_rd = (c % 5 == 4);
         @(negedge clk);
         if (pix_rd) begin
            check("stream_valid", 32'(pix_valid), 1);
            check("stream_data", 32'(pix_data), 32'(pat(pops)));
            pops++;
         end
      end
      tick(1);
      pix_rd = 1'b0;
      repeat (30) @(negedge clk);
      check("stream_pops", pops, FW);
      check("stream_uf", 32'(underflow), 0);
      check("stream_done", 32'(frame_done), 1);
      check("stream_reqs", req_count, FW);
      check("stream_empty", 32'(pix_valid), 0);

      // Frame end with continuous pops
      @(posedge clk);
      #1;
      req_count = 0;
      pulse_start();
      pix_rd = 1'b1;
      @(negedge clk);
      check("restart_done_clr", 32'(frame_done), 0);
      check("restart_addr_clr", 32'(sram_addr), 0);
      for (int i = 0; i < 400 && !frame_done; i++)
         @(negedge clk);
      check("end_done", 32'(frame_done), 1);
      check("end_addr", 32'(sram_addr), 0);
      check("end_reqs", req_count, FW);
      repeat (20) @(negedge clk);
      check("end_no_more_reqs", req_count, FW);
      check("end_start_n", 32'(sram_start_n), 1);
      tick(1);
      pix_rd = 1'b0;

      // Underflow: sticky, cleared by restart
      pulse_start();
      pix_rd = 1'b1;
      @(negedge clk);
      check("uf_restart_clr", 32'(underflow), 0);
      check("uf_fill0", 32'(fill), 0);
      tick(1);
      pix_rd = 1'b0;
      @(negedge clk);
      check("uf_set", 32'(underflow), 1);
      repeat (10) @(negedge clk);
      check("uf_sticky", 32'(underflow), 1);
      tick(1);
      pulse_start();
      @(negedge clk);
      check("uf_clear", 32'(underflow), 0);

      // Restart during WAIT_DONE at address 7
      busy = 4;
      wait_req(7, "wait_req7");
      tick(2);
      pulse_start();
      @(negedge clk);
      check("mid_fill", 32'(fill), 0);
      check("mid_addr", 32'(sram_addr), 0);
      wait_req(-1, "wait_req_after_drain");
      check("mid_req_addr", 32'(sram_addr), 0);
      check("mid_req_fill", 32'(fill), 0);
      busy = 2;

      // Reset in WAIT_ACK
      wait_req(3, "wait_req3");
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      @(negedge clk);
      check("mrst_start_n", 32'(sram_start_n), 1);
      check("mrst_addr", 32'(sram_addr), 0);
      check("mrst_fill", 32'(fill), 0);
      check("mrst_valid", 32'(pix_valid), 0);
      check("mrst_pix_data", 32'(pix_data), 0);
      check("mrst_underflow", 32'(underflow), 0);
      check("mrst_done", 32'(frame_done), 0);
      wait_req(-1, "wait_req_after_reset");
      check("mrst_req_addr", 32'(sram_addr), 0);

      repeat (20) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_line_prefetch.md
# vga_line_prefetch

Read-ahead stage between the SRAM controller's read side (through the data/ready muxes) and the VGA pixel path. It walks the displayed frame buffer sequentially, issuing single-word read transactions on the `start_n`/`rw`/`ready` handshake and storing the returned pixels in a small show-ahead FIFO. The VGA side pops one pixel per active-area clock without seeing SRAM latency. Each frame is restarted by a `frame_start` pulse derived from VGA vsync.

## Interface
- `FRAME_WORDS`, 19200: pixels per frame; read addresses run 0..FRAME_WORDS-1.
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 4.
- `DATA_W`, 12: pixel width; the pixel is taken from `sram_data[DATA_W-1:0]`.
- `clk  in  1`: system clock. Everything in the block is synchronous to it; there is one clock.
- `reset  in  1`: synchronous, active-high reset.
- `frame_start  in  1`: one-cycle pulse; flush the FIFO and restart at address 0.
- `sram_ready  in  1`: SRAM controller idle/done flag.
- `sram_data  in  16`: SRAM read data, valid on the cycle `sram_ready` rises.
- `sram_addr  out  16`: read address, registered.
- `sram_start_n  out  1`: active-low, one-cycle request strobe.
- `sram_rw  out  1`: driven constant 1 (read).
- `pix_rd  in  1`: pop request from the VGA side.
- `pix_data  out  DATA_W`: FIFO head, show-ahead.
- `pix_valid  out  1`: FIFO non-empty.
- `fill  out  $clog2(DEPTH)+1`: current FIFO occupancy.
- `underflow  out  1`: sticky flag; set by a pop while empty.
- `frame_done  out  1`: high once all FRAME_WORDS reads of the frame have been issued and completed.

## Operation
- Reset values:
  - `sram_addr`=0, `sram_start_n`=1, `sram_rw`=1.
  - `pix_data`=0, `pix_valid`=0, `fill`=0.
  - `underflow`=0, `frame_done`=0.
  - FSM in IDLE, read pointer = write pointer = 0.
- FSM states:
  - IDLE: if `fill` < DEPTH, `frame_done`=0 and `sram_ready`=1, go to REQ.
  - REQ: `sram_start_n`=0 for exactly this cycle; go to WAIT_ACK.
  - WAIT_ACK: wait for `sram_ready`=0, then go to WAIT_DONE.
  - WAIT_DONE: on the first cycle with `sram_ready`=1:
    - write `sram_data[DATA_W-1:0]` into the FIFO;
    - increment `sram_addr`;
    - if the completed address was FRAME_WORDS-1, set `frame_done`, wrap `sram_addr` to 0 and go to DONE; otherwise go to IDLE.
  - DONE: hold; issue no requests until `frame_start`.
  - DRAIN: see `frame_start` handling below.
- Only one SRAM transaction is outstanding at a time. A request is issued only when a free slot exists (`fill` < DEPTH), so the FIFO never overflows.
- `sram_addr` is stable from REQ through the WAIT_DONE completion cycle.
- Pop: `pix_rd`=1 with `pix_valid`=1 advances the read pointer.
- Pop while empty: `pix_rd`=1 with `pix_valid`=0 sets `underflow`, leaves pointers unchanged, and `pix_data` holds its value.
- Push and pop in the same cycle: `fill` is unchanged and both pointers advance. If the FIFO is empty at that moment, the pop counts as an underflow and the pushed word stays in the FIFO.
- Pointers wrap modulo DEPTH; `fill` saturates at neither end because the issue logic prevents overflow.
- `frame_start` (has priority over pop and push in the same cycle):
  - clear FIFO pointers, `fill`, `underflow` and `frame_done`;
  - set `sram_addr`=0;
  - if a transaction is in flight (REQ, WAIT_ACK or WAIT_DONE), go to DRAIN;
  - DRAIN finishes the handshake (ready low, then high), discards the returned data, and goes to IDLE.
- `frame_start` arriving while in DRAIN keeps the FSM in DRAIN.
- `reset` at any cycle returns every output to its reset value next cycle, even mid-transaction. The SRAM controller shares the same reset.

## Timing
- All outputs are registered except `pix_data` and `pix_valid`, which are decoded combinationally from registered FIFO state.
- IDLE→REQ takes 1 cycle after the condition is met; `sram_start_n` goes low the cycle after IDLE sees `sram_ready`=1.
- Completion to visibility: data captured on the WAIT_DONE completion edge gives `pix_valid`=1 and the new `fill` on the next cycle.
- Best-case request loop is IDLE, REQ, WAIT_ACK, WAIT_DONE: at least 4 clocks per word plus SRAM busy time.
- `frame_start` effect: its clearing takes effect on the following cycle. The first post-restart request (when no transaction is in flight) has `sram_start_n` low 2 cycles after the pulse.

## Test plan
- **Fill:** reset, then a controller model that drops ready for 2 cycles per request, no pops.
  - Exactly 16 requests are issued, to addresses 0..15, and then none.
  - `fill`=16; `pix_data` equals the word from address 0.
- **Steady stream:** pop every 5th cycle with a 2-cycle SRAM busy time.
  - `underflow` stays 0.
  - Popped data sequence equals the SRAM contents for addresses 0..FRAME_WORDS-1, in order.
- **Frame end:** FRAME_WORDS=20, pop continuously.
  - `frame_done` rises after the completion of address 19.
  - No request is issued afterwards; `sram_addr` reads 0.
- **Underflow:** pop with `fill`=0.
  - `underflow`=1 and stays set.
  - `frame_start` clears it next cycle.
- **Restart mid-transaction:** `frame_start` pulsed during WAIT_DONE at address 7.
  - The stale word is not pushed; `fill`=0.
  - The next request after the handshake completes goes to address 0.
- **Reset mid-transaction:** reset asserted in WAIT_ACK.
  - All outputs return to their reset values next cycle.
  - The first request after release goes to address 0.
